// File: rtl/ram64x18_rt_lite.sv
// Behavioural 64x18 micro-RAM: one synchronous write port (C), two pipelined read ports (A, B).
// Optional define COLLISION_WARN_EN adds a simulation-only same-row read/write warning.
module ram64x18_rt_lite #(
    parameter int INIT_ZERO = 1
) (
    input  logic        clock,
    input  logic        reset_n,

    input  logic [6:0]  A_ADDR,
    input  logic [1:0]  A_BLK,
    input  logic        A_WIDTH,
    input  logic        A_ADDR_EN,
    input  logic        A_ADDR_SRST_N,
    input  logic        A_ADDR_BYPASS,
    input  logic        A_DOUT_EN,
    input  logic        A_DOUT_SRST_N,
    input  logic        A_DOUT_BYPASS,
    output logic [17:0] A_DOUT,

    input  logic [6:0]  B_ADDR,
    input  logic [1:0]  B_BLK,
    input  logic        B_WIDTH,
    input  logic        B_ADDR_EN,
    input  logic        B_ADDR_SRST_N,
    input  logic        B_ADDR_BYPASS,
    input  logic        B_DOUT_EN,
    input  logic        B_DOUT_SRST_N,
    input  logic        B_DOUT_BYPASS,
    output logic [17:0] B_DOUT,

    input  logic [6:0]  C_ADDR,
    input  logic [1:0]  C_BLK,
    input  logic        C_WIDTH,
    input  logic        C_WEN,
    input  logic [17:0] C_DIN,

    output logic        BUSY
);

    localparam int          ROWS     = 64;
    localparam logic [17:0] INIT_ROW = (INIT_ZERO != 0) ? 18'h0 : 18'hx;

    // The power-up value only matters in simulation; hardware contents are undefined.
    logic [17:0] mem_q [ROWS] = '{default: INIT_ROW};

    logic        wr_en;
    logic [17:0] wr_row_d;

    logic [6:0]  a_addr_q, a_addr_eff;
    logic [17:0] a_rdata, a_dout_q;
    logic [6:0]  b_addr_q, b_addr_eff;
    logic [17:0] b_rdata, b_dout_q;

    function automatic logic [17:0] read_word(input logic [17:0] row, input logic [6:0] addr,
                                              input logic [1:0] blk, input logic width);
        if (blk != 2'b11) return 18'h0;
        if (width)        return row;
        return addr[0] ? {9'h0, row[17:9]} : {9'h0, row[8:0]};
    endfunction

    assign wr_en = C_WEN && (C_BLK == 2'b11);

    // A 9-bit write merges into the existing row so the other half is preserved.
    always_comb begin
        // NOTE: default assignment first so no path leaves wr_row_d unassigned (no latch).
        wr_row_d = mem_q[C_ADDR[6:1]];
        if (C_WIDTH) begin
            wr_row_d = C_DIN;
        end else if (C_ADDR[0]) begin
            wr_row_d[17:9] = C_DIN[8:0];
        end else begin
            wr_row_d[8:0] = C_DIN[8:0];
        end
    end

    // NOTE: the storage array has no reset; reset_n only touches the pipeline registers.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[C_ADDR[6:1]] <= wr_row_d;
        end
    end

    // Port A
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_addr_q <= '0;
            a_dout_q <= '0;
        end else begin
            if (!A_ADDR_SRST_N)  a_addr_q <= '0;
            else if (A_ADDR_EN)  a_addr_q <= A_ADDR;
            if (!A_DOUT_SRST_N)  a_dout_q <= '0;
            else if (A_DOUT_EN)  a_dout_q <= a_rdata;
        end
    end

    assign a_addr_eff = A_ADDR_BYPASS ? A_ADDR : a_addr_q;
    assign a_rdata    = read_word(mem_q[a_addr_eff[6:1]], a_addr_eff, A_BLK, A_WIDTH);
    assign A_DOUT     = A_DOUT_BYPASS ? a_rdata : a_dout_q;

    // Port B
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            b_addr_q <= '0;
            b_dout_q <= '0;
        end else begin
            if (!B_ADDR_SRST_N)  b_addr_q <= '0;
            else if (B_ADDR_EN)  b_addr_q <= B_ADDR;
            if (!B_DOUT_SRST_N)  b_dout_q <= '0;
            else if (B_DOUT_EN)  b_dout_q <= b_rdata;
        end
    end

    assign b_addr_eff = B_ADDR_BYPASS ? B_ADDR : b_addr_q;
    assign b_rdata    = read_word(mem_q[b_addr_eff[6:1]], b_addr_eff, B_BLK, B_WIDTH);
    assign B_DOUT     = B_DOUT_BYPASS ? b_rdata : b_dout_q;

    assign BUSY = 1'b0;

`ifdef COLLISION_WARN_EN
    always @(posedge clock) begin
        if (wr_en && (A_BLK == 2'b11) && (a_addr_eff[6:1] == C_ADDR[6:1])) begin
            $display("%0t: collision warning port A addr %0d", $time, a_addr_eff);
        end
        if (wr_en && (B_BLK == 2'b11) && (b_addr_eff[6:1] == C_ADDR[6:1])) begin
            $display("%0t: collision warning port B addr %0d", $time, b_addr_eff);
        end
    end
`endif

endmodule

// File: tb/tb_ram64x18_rt_lite.sv
// Directed self-checking bench for ram64x18_rt_lite: FIFO, pipelined, bypass, reset and clear paths.
module tb_ram64x18_rt_lite;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [6:0]  A_ADDR, B_ADDR, C_ADDR;
    logic [1:0]  A_BLK, B_BLK, C_BLK;
    logic        A_WIDTH, A_ADDR_EN, A_ADDR_SRST_N, A_ADDR_BYPASS, A_DOUT_EN, A_DOUT_SRST_N, A_DOUT_BYPASS;
    logic        B_WIDTH, B_ADDR_EN, B_ADDR_SRST_N, B_ADDR_BYPASS, B_DOUT_EN, B_DOUT_SRST_N, B_DOUT_BYPASS;
    logic        C_WIDTH, C_WEN;
    logic [17:0] C_DIN;
    logic [17:0] A_DOUT, B_DOUT;
    logic        BUSY;

    int errors = 0;
    int checks = 0;

    ram64x18_rt_lite dut (
        .clock(clock), .reset_n(reset_n),
        .A_ADDR(A_ADDR), .A_BLK(A_BLK), .A_WIDTH(A_WIDTH), .A_ADDR_EN(A_ADDR_EN),
        .A_ADDR_SRST_N(A_ADDR_SRST_N), .A_ADDR_BYPASS(A_ADDR_BYPASS), .A_DOUT_EN(A_DOUT_EN),
        .A_DOUT_SRST_N(A_DOUT_SRST_N), .A_DOUT_BYPASS(A_DOUT_BYPASS), .A_DOUT(A_DOUT),
        .B_ADDR(B_ADDR), .B_BLK(B_BLK), .B_WIDTH(B_WIDTH), .B_ADDR_EN(B_ADDR_EN),
        .B_ADDR_SRST_N(B_ADDR_SRST_N), .B_ADDR_BYPASS(B_ADDR_BYPASS), .B_DOUT_EN(B_DOUT_EN),
        .B_DOUT_SRST_N(B_DOUT_SRST_N), .B_DOUT_BYPASS(B_DOUT_BYPASS), .B_DOUT(B_DOUT),
        .C_ADDR(C_ADDR), .C_BLK(C_BLK), .C_WIDTH(C_WIDTH), .C_WEN(C_WEN), .C_DIN(C_DIN),
        .BUSY(BUSY)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%05h expected 0x%05h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit so outputs are sampled off the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write(input logic [6:0] addr, input logic width, input logic [17:0] din);
        C_ADDR  = addr;
        C_WIDTH = width;
        C_DIN   = din;
        C_WEN   = 1'b1;
        tick();
        C_WEN   = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        A_ADDR = 7'd0; A_BLK = 2'b11; A_WIDTH = 1'b0; A_ADDR_EN = 1'b1; A_ADDR_SRST_N = 1'b1;
        A_ADDR_BYPASS = 1'b0; A_DOUT_EN = 1'b1; A_DOUT_SRST_N = 1'b1; A_DOUT_BYPASS = 1'b1;
        B_ADDR = 7'd0; B_BLK = 2'b11; B_WIDTH = 1'b1; B_ADDR_EN = 1'b1; B_ADDR_SRST_N = 1'b1;
        B_ADDR_BYPASS = 1'b0; B_DOUT_EN = 1'b1; B_DOUT_SRST_N = 1'b1; B_DOUT_BYPASS = 1'b0;
        C_ADDR = 7'd0; C_BLK = 2'b11; C_WIDTH = 1'b0; C_WEN = 1'b0; C_DIN = 18'h0;

        #12;
        check("reset_a_dout", A_DOUT, 18'h0);
        check("reset_b_dout", B_DOUT, 18'h0);
        check("busy", {17'h0, BUSY}, 18'h0);
        #5 reset_n = 1'b1;
        tick();

        // FIFO configuration: registered address, bypassed output
        write(7'd3, 1'b0, 18'h0005A);
        A_ADDR = 7'd3;
        #1 check("fifo_before_edge", A_DOUT, 18'h0);
        tick();
        check("fifo_read", A_DOUT, 18'h0005A);

        // 9-bit halves of one row
        write(7'd6, 1'b0, 18'h001FF);
        write(7'd7, 1'b0, 18'h00003);
        A_WIDTH = 1'b1; A_ADDR = 7'd6;
        tick();
        check("halves_18bit", A_DOUT, 18'h007FF);
        A_WIDTH = 1'b0; A_ADDR = 7'd7;
        tick();
        check("halves_hi", A_DOUT, 18'h00003);
        A_ADDR = 7'd6;
        tick();
        check("halves_lo", A_DOUT, 18'h001FF);

        // Full pipeline on port B: two cycles of latency, then hold
        write(7'd10, 1'b1, 18'h2AAAA);
        B_ADDR = 7'd10;
        tick();
        check("pipe_lat1", B_DOUT, 18'h0);
        tick();
        check("pipe_lat2", B_DOUT, 18'h2AAAA);
        B_DOUT_EN = 1'b0; B_ADDR = 7'd6;
        tick();
        tick();
        check("pipe_hold", B_DOUT, 18'h2AAAA);
        B_DOUT_EN = 1'b1;
        tick();
        check("pipe_reload", B_DOUT, 18'h007FF);
        B_ADDR_BYPASS = 1'b1; B_DOUT_BYPASS = 1'b1; B_ADDR = 7'd10;
        #1 check("pipe_zero_latency", B_DOUT, 18'h2AAAA);
        B_ADDR_BYPASS = 1'b0; B_DOUT_BYPASS = 1'b0;

        // Block selects
        C_BLK = 2'b01;
        write(7'd3, 1'b0, 18'h000FF);
        C_BLK = 2'b11;
        A_ADDR = 7'd3;
        tick();
        check("blk_write_ignored", A_DOUT, 18'h0005A);
        A_BLK = 2'b10;
        #1 check("blk_read_zero", A_DOUT, 18'h0);
        A_BLK = 2'b11;

        // Asynchronous reset while the output register holds data
        A_DOUT_BYPASS = 1'b0;
        tick();
        tick();
        check("rst_registered", A_DOUT, 18'h0005A);
        #2 reset_n = 1'b0;
        #1 check("rst_async_a", A_DOUT, 18'h0);
        check("rst_async_b", B_DOUT, 18'h0);
        #1 reset_n = 1'b1;
        tick();
        tick();
        check("rst_array_kept", A_DOUT, 18'h0005A);

        // Synchronous clears
        A_DOUT_SRST_N = 1'b0;
        tick();
        check("dout_srst", A_DOUT, 18'h0);
        A_DOUT_SRST_N = 1'b1;
        tick();
        check("dout_srst_release", A_DOUT, 18'h0005A);
        A_ADDR_SRST_N = 1'b0; A_DOUT_BYPASS = 1'b1;
        tick();
        check("addr_srst", A_DOUT, 18'h0);
        A_ADDR_SRST_N = 1'b1;
        tick();
        check("addr_srst_release", A_DOUT, 18'h0005A);

        // Same-row write and address capture on one edge: new data is returned
        A_ADDR = 7'd12; B_ADDR = 7'd12; B_WIDTH = 1'b0;
        write(7'd12, 1'b0, 18'h000AB);
        check("collision_a", A_DOUT, 18'h000AB);
        tick();
        check("collision_b", B_DOUT, 18'h000AB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
